// File: rtl/alu_ctl_seq_if.sv
// Handshake and decode-field bundle between decode and the ALU-control stage.
interface alu_ctl_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] aluop;
  logic [6:0] func7;
  logic [2:0] func3;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] aluctl;
  logic       illegal;
  logic       busy;

  // Decode side plus execute-side ready: drives the stage.
  modport master (
    output in_valid, aluop, func7, func3, flush, out_ready,
    input  in_ready, out_valid, aluctl, illegal, busy
  );

  // The ALU-control stage itself.
  modport slave (
    input  in_valid, aluop, func7, func3, flush, out_ready,
    output in_ready, out_valid, aluctl, illegal, busy
  );
endinterface

// File: rtl/alu_ctl_seq.sv
// Registered ALU-control stage: decodes aluop/func7/func3 into a 5-bit ALU
// control word and holds it for a configurable number of cycles on MUL/DIV.
module alu_ctl_seq #(
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned DIV_LAT  = 8
) (
  input logic          clk,
  input logic          rst,
  alu_ctl_seq_if.slave bus
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : '0;
  localparam logic [CNT_W-1:0] DIV_CNT = (DIV_LAT > 1) ? CNT_W'(DIV_LAT - 2) : '0;

  typedef enum logic [4:0] {
    ALU_AND     = 5'b00000,
    ALU_OR      = 5'b00001,
    ALU_ADD     = 5'b00010,
    ALU_SLL     = 5'b00011,
    ALU_SRL     = 5'b00100,
    ALU_SRA     = 5'b00101,
    ALU_SUB     = 5'b00110,
    ALU_SLT     = 5'b00111,
    ALU_SLTU    = 5'b01000,
    ALU_XOR     = 5'b01100,
    ALU_ILLEGAL = 5'b11111
  } alu_op_e;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       aluctl_q, aluctl_d;
  logic             illegal_q, illegal_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [4:0] dec_ctl;
  logic       dec_ill;
  logic       dec_mul;
  logic       dec_div;
  logic       in_ready;
  logic       accept;

  // Base RV32I register/immediate op selected by func3 alone.
  function automatic logic [4:0] base_op(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Combinational decode of the incoming op; illegal is implied by the code.
  always_comb begin
    dec_ctl = ALU_ILLEGAL;
    dec_mul = 1'b0;
    dec_div = 1'b0;
    case (bus.aluop)
      2'b00: begin
        dec_ctl = base_op(bus.func3);
        if (bus.func3 == 3'b001 && bus.func7 != 7'b0000000) begin
          dec_ctl = ALU_ILLEGAL;
        end else if (bus.func3 == 3'b101) begin
          if (bus.func7 == 7'b0000000) begin
            dec_ctl = ALU_SRL;
          end else if (bus.func7 == 7'b0100000) begin
            dec_ctl = ALU_SRA;
          end else begin
            dec_ctl = ALU_ILLEGAL;
          end
        end
      end
      2'b01: dec_ctl = ALU_SUB;
      2'b11: dec_ctl = ALU_ADD;
      default: begin
        case (bus.func7)
          7'b0000000: dec_ctl = base_op(bus.func3);
          7'b0100000: begin
            if (bus.func3 == 3'b000) begin
              dec_ctl = ALU_SUB;
            end else if (bus.func3 == 3'b101) begin
              dec_ctl = ALU_SRA;
            end
          end
          7'b0000001: begin
            if (ENABLE_M) begin
              dec_ctl = {2'b10, bus.func3};
              dec_mul = ~bus.func3[2];
              dec_div = bus.func3[2];
            end
          end
          default: ;
        endcase
      end
    endcase
    dec_ill = (dec_ctl == ALU_ILLEGAL);
  end

  assign in_ready = (state_q == S_IDLE) && !bus.flush && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Next-state and output-register logic; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    aluctl_d    = aluctl_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    if (bus.flush) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      aluctl_d    = '0;
      illegal_d   = 1'b0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            aluctl_d  = dec_ctl;
            illegal_d = dec_ill;
            if (dec_mul && MUL_LAT > 1) begin
              state_d     = S_BUSY;
              cnt_d       = MUL_CNT;
              busy_d      = 1'b1;
              out_valid_d = 1'b0;
            end else if (dec_div && DIV_LAT > 1) begin
              state_d     = S_BUSY;
              cnt_d       = DIV_CNT;
              busy_d      = 1'b1;
              out_valid_d = 1'b0;
            end else begin
              out_valid_d = 1'b1;
            end
          end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
          end
        end
        default: begin
          if (cnt_q == '0) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      aluctl_q    <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      aluctl_q    <= aluctl_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.aluctl    = aluctl_q;
  assign bus.illegal   = illegal_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_ctl_seq.sv
// Scoreboard bench for alu_ctl_seq: one instance with the M extension and
// multi-cycle latencies, one without the M extension and unit latencies.
module tb_alu_ctl_seq;

  localparam int unsigned A_MUL = 3;
  localparam int unsigned A_DIV = 8;

  typedef struct {
    logic [4:0]  ctl;
    logic        ill;
    int unsigned lat;
    int unsigned due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned ecount = 0;
  int checks = 0;
  int failures = 0;
  exp_t qa[$];
  exp_t qb[$];

  alu_ctl_seq_if bus_a ();
  alu_ctl_seq_if bus_b ();

  alu_ctl_seq #(.ENABLE_M(1'b1), .MUL_LAT(A_MUL), .DIV_LAT(A_DIV)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  alu_ctl_seq #(.ENABLE_M(1'b0), .MUL_LAT(1), .DIV_LAT(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecount <= ecount + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, exp, ecount);
    end
  endtask

  // Reference decode written from the op tables: returns {illegal, aluctl}.
  function automatic logic [5:0] ref_dec(input logic [1:0] op, input logic [6:0] f7,
                                         input logic [2:0] f3, input bit en_m);
    int base [8] = '{2, 3, 7, 8, 12, 4, 1, 0};
    int code;
    code = 31;
    if (op == 2'd1) code = 6;
    else if (op == 2'd3) code = 2;
    else if (op == 2'd0) begin
      if (f3 == 3'd1) code = (f7 == 7'd0) ? 3 : 31;
      else if (f3 == 3'd5) code = (f7 == 7'd0) ? 4 : (f7 == 7'h20) ? 5 : 31;
      else code = base[f3];
    end else begin
      if (f7 == 7'd0) code = base[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) code = 6;
      else if (f7 == 7'h20 && f3 == 3'd5) code = 5;
      else if (f7 == 7'h01 && en_m) code = 16 + int'(f3);
    end
    return {code == 31, 5'(code)};
  endfunction

  function automatic int unsigned ref_lat(input logic [5:0] r, input int unsigned ml,
                                          input int unsigned dl);
    int unsigned c;
    c = int'(r[4:0]);
    if (r[5] || c < 16) return 1;
    if (c < 20) return ml;
    return dl;
  endfunction

  function automatic logic [6:0] pick_f7();
    logic [6:0] f;
    case ($urandom_range(0, 3))
      0: f = 7'h00;
      1: f = 7'h20;
      2: f = 7'h01;
      default: f = 7'($urandom);
    endcase
    return f;
  endfunction

  // Retire model entries on the transfer edge (model-timed, not DUT-timed).
  always @(posedge clk) begin
    if (!rst) begin
      if (bus_a.flush) qa.delete();
      else if (qa.size() > 0 && ecount >= qa[0].due && bus_a.out_ready) void'(qa.pop_front());
    end
  end

  // Monitor A: compare presented outputs against the scoreboard head.
  always @(negedge clk) begin
    bit have, ov_e, busy_e;
    if (!rst) begin
      have   = qa.size() > 0;
      ov_e   = have && ecount >= qa[0].due;
      busy_e = have && qa[0].lat > 1 && ecount < qa[0].due;
      chk("a_out_valid", 32'(bus_a.out_valid), 32'(ov_e));
      chk("a_busy", 32'(bus_a.busy), 32'(busy_e));
      if (ov_e && bus_a.out_valid) begin
        chk("a_aluctl", 32'(bus_a.aluctl), 32'(qa[0].ctl));
        chk("a_illegal", 32'(bus_a.illegal), 32'(qa[0].ill));
      end
    end
  end

  // Monitor B: always-ready sink, every op completes in one cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("b_out_valid", 32'(bus_b.out_valid), 32'(qb.size() > 0));
      chk("b_busy", 32'(bus_b.busy), 0);
      if (qb.size() > 0 && bus_b.out_valid) begin
        e = qb.pop_front();
        chk("b_aluctl", 32'(bus_b.aluctl), 32'(e.ctl));
        chk("b_illegal", 32'(bus_b.illegal), 32'(e.ill));
      end
    end
  end

  task automatic drive_a(input bit v, input logic [1:0] op, input logic [6:0] f7,
                         input logic [2:0] f3, input bit fl, input bit ordy, output bit acc);
    exp_t e;
    bit have, busy_e, ov_e, rdy_e;
    logic [5:0] r;
    @(negedge clk);
    #2;
    bus_a.in_valid  = v;
    bus_a.aluop     = op;
    bus_a.func7     = f7;
    bus_a.func3     = f3;
    bus_a.flush     = fl;
    bus_a.out_ready = ordy;
    #1;
    have   = qa.size() > 0;
    busy_e = have && qa[0].lat > 1 && ecount < qa[0].due;
    ov_e   = have && ecount >= qa[0].due;
    rdy_e  = !busy_e && !fl && (!ov_e || ordy);
    chk("a_in_ready", 32'(bus_a.in_ready), 32'(rdy_e));
    acc = v && rdy_e;
    if (acc) begin
      r     = ref_dec(op, f7, f3, 1'b1);
      e.ctl = r[4:0];
      e.ill = r[5];
      e.lat = ref_lat(r, A_MUL, A_DIV);
      e.due = ecount + e.lat;
      qa.push_back(e);
    end
  endtask

  task automatic drive_b(input bit v, input logic [1:0] op, input logic [6:0] f7,
                         input logic [2:0] f3);
    exp_t e;
    logic [5:0] r;
    @(negedge clk);
    #2;
    bus_b.in_valid = v;
    bus_b.aluop    = op;
    bus_b.func7    = f7;
    bus_b.func3    = f3;
    #1;
    chk("b_in_ready", 32'(bus_b.in_ready), 1);
    if (v) begin
      r     = ref_dec(op, f7, f3, 1'b0);
      e.ctl = r[4:0];
      e.ill = r[5];
      e.lat = 1;
      e.due = ecount + 1;
      qb.push_back(e);
    end
  endtask

  task automatic idle_a(input int unsigned n);
    bit acc;
    for (int unsigned i = 0; i < n; i++) drive_a(1'b0, 2'd0, 7'd0, 3'd0, 1'b0, 1'b1, acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    bit acc, hold, v, fl, ordy;
    logic [1:0] op;
    logic [6:0] f7;
    logic [2:0] f3;

    bus_a.in_valid = 1'b0; bus_a.aluop = '0; bus_a.func7 = '0; bus_a.func3 = '0;
    bus_a.flush = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.aluop = '0; bus_b.func7 = '0; bus_b.func3 = '0;
    bus_b.flush = 1'b0; bus_b.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus_a.out_valid), 0);
    chk("rst_busy", 32'(bus_a.busy), 0);
    chk("rst_aluctl", 32'(bus_a.aluctl), 0);
    chk("rst_illegal", 32'(bus_a.illegal), 0);
    #2 rst = 1'b0;

    // Back-to-back SRA, ADD, SUB with a ready sink.
    drive_a(1'b1, 2'b10, 7'h20, 3'b101, 1'b0, 1'b1, acc);
    drive_a(1'b1, 2'b10, 7'h00, 3'b000, 1'b0, 1'b1, acc);
    drive_a(1'b1, 2'b10, 7'h20, 3'b000, 1'b0, 1'b1, acc);
    idle_a(2);

    // DIVU then MUL multi-cycle issue.
    drive_a(1'b1, 2'b10, 7'h01, 3'b101, 1'b0, 1'b1, acc);
    idle_a(10);
    drive_a(1'b1, 2'b10, 7'h01, 3'b000, 1'b0, 1'b1, acc);
    idle_a(5);

    // Backpressure on XOR, then release with a new op in the same cycle.
    drive_a(1'b1, 2'b00, 7'h00, 3'b100, 1'b0, 1'b1, acc);
    repeat (3) drive_a(1'b1, 2'b11, 7'h00, 3'b000, 1'b0, 1'b0, acc);
    drive_a(1'b1, 2'b11, 7'h00, 3'b000, 1'b0, 1'b1, acc);
    chk("bp_release_accept", 32'(bus_a.in_ready), 1);
    idle_a(2);

    // Illegal shift encoding on the immediate path.
    drive_a(1'b1, 2'b00, 7'h20, 3'b001, 1'b0, 1'b1, acc);
    idle_a(2);

    // Flush during DIV; the op offered with flush is not accepted.
    drive_a(1'b1, 2'b10, 7'h01, 3'b100, 1'b0, 1'b1, acc);
    idle_a(2);
    drive_a(1'b1, 2'b10, 7'h00, 3'b000, 1'b1, 1'b0, acc);
    @(negedge clk);
    #1;
    chk("flush_aluctl", 32'(bus_a.aluctl), 0);
    chk("flush_illegal", 32'(bus_a.illegal), 0);
    drive_a(1'b1, 2'b10, 7'h00, 3'b000, 1'b0, 1'b1, acc);
    idle_a(2);

    // Asynchronous reset in the middle of a MUL.
    drive_a(1'b1, 2'b10, 7'h01, 3'b000, 1'b0, 1'b1, acc);
    idle_a(1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    qa.delete();
    qb.delete();
    #1;
    chk("arst_out_valid", 32'(bus_a.out_valid), 0);
    chk("arst_busy", 32'(bus_a.busy), 0);
    chk("arst_aluctl", 32'(bus_a.aluctl), 0);
    chk("arst_in_ready", 32'(bus_a.in_ready), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    drive_a(1'b1, 2'b00, 7'h00, 3'b000, 1'b0, 1'b1, acc);
    idle_a(2);

    // Randomised traffic with holding upstream, random sink and rare flush.
    hold = 1'b0;
    v = 1'b0; op = '0; f7 = '0; f3 = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!hold) begin
        v  = ($urandom_range(0, 9) < 7);
        op = 2'($urandom_range(0, 3));
        f7 = pick_f7();
        f3 = 3'($urandom);
      end
      fl   = ($urandom_range(0, 39) == 0);
      ordy = ($urandom_range(0, 9) < 7);
      drive_a(v, op, f7, f3, fl, ordy, acc);
      hold = v && !acc;
    end
    idle_a(12);
    chk("a_drain", 32'(qa.size()), 0);

    // No-M instance: M ops illegal and single-cycle, full throughput.
    drive_b(1'b1, 2'b10, 7'h01, 3'b000);
    drive_b(1'b1, 2'b10, 7'h01, 3'b101);
    drive_b(1'b1, 2'b00, 7'h20, 3'b001);
    drive_b(1'b1, 2'b10, 7'h20, 3'b101);
    for (int i = 0; i < 300; i++) begin
      drive_b(1'b1, 2'($urandom_range(0, 3)), pick_f7(), 3'($urandom));
    end
    drive_b(1'b0, 2'd0, 7'd0, 3'd0);
    drive_b(1'b0, 2'd0, 7'd0, 3'd0);
    chk("b_drain", 32'(qb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_ctl_seq.md
Name: alu_ctl_seq

Overview:
- Parametrised, registered ALU-control stage for the RISC-V pipeline, sitting between decode and execute.
- Decodes aluop/func7/func3 into a 5-bit ALU control word covering full RV32I ALU ops, with optional M-extension.
- Sequences multi-cycle MUL/DIV issue: holds the control word stable and stalls upstream for a parametrised number of cycles.
- Provides valid/ready handshakes on both sides, plus flush and illegal-op flagging.

Parameters:
- ENABLE_M, 1: 1 decodes M-extension ops; 0 flags them illegal.
- MUL_LAT, 3: cycles from accept to out_valid for MUL-class ops (>=1).
- DIV_LAT, 8: cycles from accept to out_valid for DIV/REM-class ops (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  decode-side op valid
- in_ready  out  1  stage can accept
- aluop  in  2  00 I-type ALU, 01 branch compare, 10 R-type, 11 load/store address
- func7  in  7  instruction[31:25]
- func3  in  3  instruction[14:12]
- flush  in  1  synchronous pipeline flush
- out_valid  out  1  aluctl valid to execute
- out_ready  in  1  execute accepts
- aluctl  out  5  ALU control word
- illegal  out  1  op undecodable; qualified by out_valid
- busy  out  1  multi-cycle op in progress

Behaviour:
- Encodings:
  - AND 00000, OR 00001, ADD 00010, SLL 00011, SRL 00100, SRA 00101, SUB 00110, SLT 00111, SLTU 01000, XOR 01100.
  - MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
  - ILLEGAL 11111.
- aluop 00 (func3 selects the op):
  - 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 001 SLL only if func7=0000000, else illegal.
  - 101: func7 0000000 gives SRL, 0100000 gives SRA, else illegal.
- aluop 01 gives SUB. aluop 11 gives ADD. func7/func3 are ignored for both.
- aluop 10 with func7 0000000: func3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- aluop 10 with func7 0100000: func3 000 SUB, 101 SRA, else illegal.
- aluop 10 with func7 0000001:
  - ENABLE_M=1: func3 maps directly to 10000+func3.
  - ENABLE_M=0: illegal.
- Any other func7 with aluop 10 is illegal.
- Illegal ops drive aluctl=11111, illegal=1, and are treated as single-cycle.
- States IDLE, BUSY.
- Reset (async): state IDLE, counter 0, aluctl 00000, out_valid 0, illegal 0, busy 0.
- in_ready = (state==IDLE) && !flush && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On accept, aluctl and illegal are registered next edge.
- Single-cycle op, or MUL with MUL_LAT=1, or DIV with DIV_LAT=1: out_valid=1 at the next edge (latency 1).
- MUL-class (func3 0xx) with MUL_LAT>1:
  - Go to BUSY, busy=1, counter=MUL_LAT-2, out_valid=0.
  - Each BUSY cycle decrements the counter.
  - The edge where the counter is 0 moves to IDLE with out_valid=1 and busy=0.
  - Net result: out_valid rises exactly MUL_LAT edges after the accept edge.
- DIV-class (func3 1xx) with DIV_LAT>1: identical, using DIV_LAT.
- aluctl is stable throughout BUSY and while out_valid && !out_ready.
- out_valid clears on out_ready unless a new accept occurs the same edge.
- Throughput is 1 op/cycle for single-cycle ops when out_ready=1.
- Counter width is $clog2(max(MUL_LAT,DIV_LAT)+1).
- Flush:
  - Next edge: out_valid 0, illegal 0, busy 0, state IDLE, counter 0, aluctl 00000.
  - Flush wins over a simultaneous accept (in_ready forced 0) and over BUSY completion.
- in_valid while BUSY is not accepted. The upstream holds its op (standard valid/ready).
- Reset asserted mid-BUSY returns all state to reset values immediately, without waiting for clk.

Test Plan:
- Reset, then aluop=10, func7=0100000, func3=101 with in_valid=1, out_ready=1 -> next cycle out_valid=1, aluctl=00101, illegal=0. Follow with ADD and SUB on consecutive cycles -> aluctl 00010 then 00110 on consecutive cycles, in_ready stays 1.
- ENABLE_M=1, DIV_LAT=8: accept DIVU (aluop=10, func7=0000001, func3=101) at edge t -> busy=1 and in_ready=0 for edges t+1..t+7, out_valid=1 with aluctl=10101 at edge t+8. MUL (func3=000) with MUL_LAT=3 -> out_valid at t+3, aluctl=10000.
- Backpressure: accept XOR (aluop=00, func3=100), hold out_ready=0 for 3 cycles -> aluctl=01100 and out_valid=1 held, in_ready=0. Raise out_ready -> a new op is accepted the same cycle.
- ENABLE_M=0, aluop=10, func7=0000001, func3=000 -> after 1 cycle aluctl=11111, illegal=1, busy never asserted. Also aluop=00, func3=001, func7=0100000 -> illegal=1.
- Accept DIV (DIV_LAT=8), assert flush at t+4 -> next edge busy=0, out_valid=0, aluctl=00000. in_valid held with flush=1 -> not accepted. Next accept proceeds normally.
- Accept MUL, assert rst at t+1 between clock edges -> outputs reset immediately. After rst release, a new ADD completes with latency 1.
